// File: rtl/rs_sched_pkg.sv
// Shared sizing, slot record and wakeup tag-match helper for the RS slot scheduler.
package rs_sched_pkg;

    localparam int BUF_COUNT      = 32;
    localparam int BANK_COUNT     = 4;
    localparam int REG_WIDTH      = 9;
    localparam int FU_COUNT       = 10;
    localparam int SLOTS_PER_BANK = BUF_COUNT / BANK_COUNT;
    localparam int BANK_W         = $clog2(BANK_COUNT);
    localparam int SPB_W          = $clog2(SLOTS_PER_BANK);
    localparam int SLOT_W         = $clog2(BUF_COUNT);
    localparam int CNT_W          = $clog2(BUF_COUNT + 1);

    typedef struct packed {
        logic                 valid;
        logic [1:0]           port;
        logic [REG_WIDTH-1:0] tag_a;
        logic [REG_WIDTH-1:0] tag_b;
        logic [REG_WIDTH-1:0] tag_s;
        logic                 rdy_a;
        logic                 rdy_b;
        logic                 rdy_s;
        logic                 use_s;
    } slot_t;

    // Returns {hit, fu_index}; the lowest-numbered matching broadcast wins.
    function automatic logic [4:0] fu_match(
        input logic [REG_WIDTH-1:0]                tag,
        input logic [FU_COUNT-1:0][REG_WIDTH-1:0]  fu_reg,
        input logic [FU_COUNT-1:0]                 fu_wen
    );
        logic [4:0] res;
        res = '0;
        for (int i = FU_COUNT - 1; i >= 0; i--) begin
            if (fu_wen[i] && (fu_reg[i] == tag)) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_bank_pick.sv
// Rotating-pointer bank picker: first bank at or after ptr holding a candidate,
// lowest slot inside that bank.
module rs_bank_pick
    import rs_sched_pkg::*;
(
    input  logic [BUF_COUNT-1:0]  cand,
    input  logic [BANK_W-1:0]     ptr,
    output logic [BUF_COUNT-1:0]  sel,
    output logic [BANK_COUNT-1:0] bank,
    output logic [BANK_W-1:0]     bank_idx,
    output logic                  found
);

    logic [BANK_W-1:0] b;
    logic [SLOT_W-1:0] idx;

    // Scan banks in rotated order; bank counts are powers of two so the add wraps.
    always_comb begin
        sel      = '0;
        bank     = '0;
        bank_idx = '0;
        found    = 1'b0;
        b        = '0;
        idx      = '0;
        for (int off = 0; off < BANK_COUNT; off++) begin
            b = ptr + BANK_W'(off);
            for (int j = 0; j < SLOTS_PER_BANK; j++) begin
                idx = {b, SPB_W'(j)};
                if (!found && cand[idx]) begin
                    found     = 1'b1;
                    bank_idx  = b;
                    sel[idx]  = 1'b1;
                    bank[b]   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rs_slot_sched.sv
// Reservation-station slot control: allocation, tag wakeup and per-port issue pick.
module rs_slot_sched
    import rs_sched_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                stall,
    input  logic                                flush,
    input  logic [2:0]                          newValid,
    input  logic [2:0][1:0]                     newPort,
    input  logic [2:0][REG_WIDTH-1:0]           newTagA,
    input  logic [2:0][REG_WIDTH-1:0]           newTagB,
    input  logic [2:0][REG_WIDTH-1:0]           newTagS,
    input  logic [2:0]                          newReadyA,
    input  logic [2:0]                          newReadyB,
    input  logic [2:0]                          newReadyS,
    input  logic [2:0]                          newUseS,
    input  logic [FU_COUNT-1:0][REG_WIDTH-1:0]  FUreg,
    input  logic [FU_COUNT-1:0]                 FUwen,
    output logic [BUF_COUNT-1:0]                newRsSelect0,
    output logic [BUF_COUNT-1:0]                newRsSelect1,
    output logic [BUF_COUNT-1:0]                newRsSelect2,
    output logic                                doStall,
    output logic [BUF_COUNT-1:0][3:0]           eqIdxA,
    output logic [BUF_COUNT-1:0][3:0]           eqIdxB,
    output logic [BUF_COUNT-1:0][3:0]           eqIdxS,
    output logic [BUF_COUNT-1:0]                eqHitA,
    output logic [BUF_COUNT-1:0]                eqHitB,
    output logic [BUF_COUNT-1:0]                eqHitS,
    output logic [2:0][BUF_COUNT-1:0]           outRsSelect,
    output logic [2:0][BANK_COUNT-1:0]          outBank,
    output logic [2:0]                          rsFound
);

    slot_t slot_q [BUF_COUNT];
    slot_t slot_d [BUF_COUNT];
    slot_t eff    [BUF_COUNT];

    logic [2:0][BANK_W-1:0]     ptr_q, ptr_d;
    logic [2:0][BUF_COUNT-1:0]  out_sel_q, out_sel_d;
    logic [2:0][BANK_COUNT-1:0] out_bank_q, out_bank_d;
    logic [2:0]                 found_q, found_d;

    logic [BUF_COUNT-1:0]       free_vec, avail, alloc_vec;
    logic [BUF_COUNT-1:0][1:0]  alloc_src;
    logic [2:0][BUF_COUNT-1:0]  new_sel;
    logic [CNT_W-1:0]           free_cnt;
    logic [1:0]                 req_cnt;
    logic                       over, alloc_ok;
    logic [4:0]                 m_a, m_b, m_s;

    logic [2:0][BUF_COUNT-1:0]  cand, pick_sel;
    logic [2:0][BANK_COUNT-1:0] pick_bank;
    logic [2:0][BANK_W-1:0]     pick_idx;
    logic [2:0]                 pick_found;

    // Allocation: all-or-nothing, requests take the lowest free slots in port order.
    always_comb begin
        free_vec = '0;
        for (int s = 0; s < BUF_COUNT; s++) begin
            free_vec[s] = !slot_q[s].valid;
        end
        free_cnt  = CNT_W'($countones(free_vec));
        req_cnt   = 2'(newValid[0]) + 2'(newValid[1]) + 2'(newValid[2]);
        over      = CNT_W'(req_cnt) > free_cnt;
        alloc_ok  = !stall && !flush && !over;
        doStall   = !stall && !flush && over;
        avail     = free_vec;
        new_sel   = '0;
        alloc_vec = '0;
        alloc_src = '0;
        for (int k = 0; k < 3; k++) begin
            if (alloc_ok && newValid[k]) begin
                new_sel[k] = avail & (~avail + BUF_COUNT'(1));
                avail      = avail & ~new_sel[k];
            end
        end
        for (int s = 0; s < BUF_COUNT; s++) begin
            for (int k = 0; k < 3; k++) begin
                if (new_sel[k][s]) begin
                    alloc_vec[s] = 1'b1;
                    alloc_src[s] = 2'(k);
                end
            end
        end
    end

    // Wakeup: newly allocated entries are folded in so same-cycle broadcasts are caught.
    always_comb begin
        m_a    = '0;
        m_b    = '0;
        m_s    = '0;
        eqHitA = '0;
        eqHitB = '0;
        eqHitS = '0;
        eqIdxA = '0;
        eqIdxB = '0;
        eqIdxS = '0;
        for (int s = 0; s < BUF_COUNT; s++) begin
            eff[s] = slot_q[s];
            if (alloc_vec[s]) begin
                eff[s].valid = 1'b1;
                eff[s].port  = newPort[alloc_src[s]];
                eff[s].tag_a = newTagA[alloc_src[s]];
                eff[s].tag_b = newTagB[alloc_src[s]];
                eff[s].tag_s = newTagS[alloc_src[s]];
                eff[s].rdy_a = newReadyA[alloc_src[s]];
                eff[s].rdy_b = newReadyB[alloc_src[s]];
                eff[s].rdy_s = newReadyS[alloc_src[s]];
                eff[s].use_s = newUseS[alloc_src[s]];
            end
            m_a = fu_match(eff[s].tag_a, FUreg, FUwen);
            m_b = fu_match(eff[s].tag_b, FUreg, FUwen);
            m_s = fu_match(eff[s].tag_s, FUreg, FUwen);
            eqHitA[s] = eff[s].valid && !eff[s].rdy_a && m_a[4];
            eqHitB[s] = eff[s].valid && !eff[s].rdy_b && m_b[4];
            eqHitS[s] = eff[s].valid && !eff[s].rdy_s && m_s[4];
            eqIdxA[s] = eqHitA[s] ? m_a[3:0] : 4'd0;
            eqIdxB[s] = eqHitB[s] ? m_b[3:0] : 4'd0;
            eqIdxS[s] = eqHitS[s] ? m_s[3:0] : 4'd0;
        end
    end

    // Issue candidates come from registered state only, giving the one-cycle ready-to-issue gap.
    always_comb begin
        cand = '0;
        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < BUF_COUNT; s++) begin
                cand[p][s] = slot_q[s].valid && slot_q[s].rdy_a && slot_q[s].rdy_b &&
                             (slot_q[s].rdy_s || !slot_q[s].use_s) &&
                             (slot_q[s].port == 2'(p));
            end
        end
    end

    for (genvar p = 0; p < 3; p++) begin : g_pick
        rs_bank_pick u_pick (
            .cand     (cand[p]),
            .ptr      (ptr_q[p]),
            .sel      (pick_sel[p]),
            .bank     (pick_bank[p]),
            .bank_idx (pick_idx[p]),
            .found    (pick_found[p])
        );
    end

    // Next state: wakeup and allocation always land; flush wipes, stall blocks issue.
    always_comb begin
        ptr_d      = ptr_q;
        out_sel_d  = '0;
        out_bank_d = '0;
        found_d    = '0;
        for (int s = 0; s < BUF_COUNT; s++) begin
            slot_d[s]       = eff[s];
            slot_d[s].rdy_a = eff[s].rdy_a | eqHitA[s];
            slot_d[s].rdy_b = eff[s].rdy_b | eqHitB[s];
            slot_d[s].rdy_s = eff[s].rdy_s | eqHitS[s];
        end
        if (flush) begin
            for (int s = 0; s < BUF_COUNT; s++) begin
                slot_d[s].valid = 1'b0;
            end
        end else if (!stall) begin
            for (int p = 0; p < 3; p++) begin
                if (pick_found[p]) begin
                    out_sel_d[p]  = pick_sel[p];
                    out_bank_d[p] = pick_bank[p];
                    found_d[p]    = 1'b1;
                    ptr_d[p]      = pick_idx[p] + BANK_W'(1);
                    for (int s = 0; s < BUF_COUNT; s++) begin
                        if (pick_sel[p][s]) begin
                            slot_d[s].valid = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < BUF_COUNT; s++) begin
                slot_q[s] <= '0;
            end
            ptr_q      <= '0;
            out_sel_q  <= '0;
            out_bank_q <= '0;
            found_q    <= '0;
        end else begin
            slot_q     <= slot_d;
            ptr_q      <= ptr_d;
            out_sel_q  <= out_sel_d;
            out_bank_q <= out_bank_d;
            found_q    <= found_d;
        end
    end

    assign newRsSelect0 = new_sel[0];
    assign newRsSelect1 = new_sel[1];
    assign newRsSelect2 = new_sel[2];
    assign outRsSelect  = out_sel_q;
    assign outBank      = out_bank_q;
    assign rsFound      = found_q;

endmodule

// File: tb/tb_rs_slot_sched.sv
// Bench for rs_slot_sched: directed scenarios plus random traffic against a slot-list model.
module tb_rs_slot_sched;

    logic              clk = 1'b0;
    logic              rst, stall, flush;
    logic [2:0]        newValid;
    logic [2:0][1:0]   newPort;
    logic [2:0][8:0]   newTagA, newTagB, newTagS;
    logic [2:0]        newReadyA, newReadyB, newReadyS, newUseS;
    logic [9:0][8:0]   FUreg;
    logic [9:0]        FUwen;
    logic [31:0]       newRsSelect0, newRsSelect1, newRsSelect2;
    logic              doStall;
    logic [31:0][3:0]  eqIdxA, eqIdxB, eqIdxS;
    logic [31:0]       eqHitA, eqHitB, eqHitS;
    logic [2:0][31:0]  outRsSelect;
    logic [2:0][3:0]   outBank;
    logic [2:0]        rsFound;

    rs_slot_sched dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .newValid(newValid), .newPort(newPort),
        .newTagA(newTagA), .newTagB(newTagB), .newTagS(newTagS),
        .newReadyA(newReadyA), .newReadyB(newReadyB), .newReadyS(newReadyS),
        .newUseS(newUseS), .FUreg(FUreg), .FUwen(FUwen),
        .newRsSelect0(newRsSelect0), .newRsSelect1(newRsSelect1), .newRsSelect2(newRsSelect2),
        .doStall(doStall),
        .eqIdxA(eqIdxA), .eqIdxB(eqIdxB), .eqIdxS(eqIdxS),
        .eqHitA(eqHitA), .eqHitB(eqHitB), .eqHitS(eqHitS),
        .outRsSelect(outRsSelect), .outBank(outBank), .rsFound(rsFound)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: plain per-slot records
    bit   m_valid [32];
    int   m_port  [32];
    int   m_tag   [32][3];
    bit   m_rdy   [32][3];
    bit   m_use   [32];
    int   m_ptr   [3];
    int   e_slot  [3];
    bit           c_stall;
    logic [31:0]  c_sel [3];
    logic [31:0]  c_hit [3];
    logic [127:0] c_idx [3];
    int           c_alloc [3];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int first_fu(input int tag);
        for (int i = 0; i < 10; i++) begin
            if (FUwen[i] && (int'(FUreg[i]) == tag)) return i;
        end
        return -1;
    endfunction

    function automatic bit is_cand(input int s, input int p);
        return m_valid[s] && m_rdy[s][0] && m_rdy[s][1] && (m_rdy[s][2] || !m_use[s]) && (m_port[s] == p);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 32; s++) begin
            m_valid[s] = 0;
            for (int j = 0; j < 3; j++) m_rdy[s][j] = 0;
        end
        for (int p = 0; p < 3; p++) begin
            m_ptr[p]  = 0;
            e_slot[p] = -1;
        end
    endtask

    task automatic model_comb();
        int free_q[$];
        int nreq;
        int tg[3];
        bit rd[3];
        bit live;
        int fi;
        nreq = 0;
        for (int k = 0; k < 3; k++) nreq += int'(newValid[k]);
        for (int s = 0; s < 32; s++) if (!m_valid[s]) free_q.push_back(s);
        c_stall = 0;
        for (int k = 0; k < 3; k++) begin
            c_sel[k] = '0; c_hit[k] = '0; c_idx[k] = '0; c_alloc[k] = -1;
        end
        if (!stall && !flush) begin
            if (nreq > free_q.size()) c_stall = 1;
            else begin
                for (int k = 0; k < 3; k++) begin
                    if (newValid[k]) begin
                        c_alloc[k] = free_q.pop_front();
                        c_sel[k][c_alloc[k]] = 1'b1;
                    end
                end
            end
        end
        for (int s = 0; s < 32; s++) begin
            live = m_valid[s];
            tg = m_tag[s];
            rd = m_rdy[s];
            for (int k = 0; k < 3; k++) begin
                if (c_alloc[k] == s) begin
                    live = 1;
                    tg[0] = int'(newTagA[k]); tg[1] = int'(newTagB[k]); tg[2] = int'(newTagS[k]);
                    rd[0] = newReadyA[k];     rd[1] = newReadyB[k];     rd[2] = newReadyS[k];
                end
            end
            if (live) begin
                for (int src = 0; src < 3; src++) begin
                    if (!rd[src]) begin
                        fi = first_fu(tg[src]);
                        if (fi >= 0) begin
                            c_hit[src][s] = 1'b1;
                            c_idx[src][s*4 +: 4] = 4'(fi);
                        end
                    end
                end
            end
        end
    endtask

    task automatic model_seq();
        int pick[3];
        int pbank[3];
        int bk;
        if (flush) begin
            for (int s = 0; s < 32; s++) m_valid[s] = 0;
            for (int p = 0; p < 3; p++) e_slot[p] = -1;
            return;
        end
        for (int p = 0; p < 3; p++) begin
            pick[p] = -1;
            pbank[p] = 0;
            for (int off = 0; off < 4; off++) begin
                bk = (m_ptr[p] + off) % 4;
                for (int j = 0; j < 8; j++) begin
                    if (pick[p] < 0 && is_cand(bk*8 + j, p)) begin
                        pick[p] = bk*8 + j;
                        pbank[p] = bk;
                    end
                end
            end
        end
        for (int s = 0; s < 32; s++) begin
            if (m_valid[s]) begin
                for (int src = 0; src < 3; src++) if (c_hit[src][s]) m_rdy[s][src] = 1;
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (c_alloc[k] >= 0) begin
                m_valid[c_alloc[k]] = 1;
                m_port[c_alloc[k]]  = int'(newPort[k]);
                m_tag[c_alloc[k]][0] = int'(newTagA[k]);
                m_tag[c_alloc[k]][1] = int'(newTagB[k]);
                m_tag[c_alloc[k]][2] = int'(newTagS[k]);
                m_rdy[c_alloc[k]][0] = newReadyA[k] | c_hit[0][c_alloc[k]];
                m_rdy[c_alloc[k]][1] = newReadyB[k] | c_hit[1][c_alloc[k]];
                m_rdy[c_alloc[k]][2] = newReadyS[k] | c_hit[2][c_alloc[k]];
                m_use[c_alloc[k]]    = newUseS[k];
            end
        end
        for (int p = 0; p < 3; p++) begin
            if (stall) e_slot[p] = -1;
            else begin
                e_slot[p] = pick[p];
                if (pick[p] >= 0) begin
                    m_valid[pick[p]] = 0;
                    m_ptr[p] = (pbank[p] + 1) % 4;
                end
            end
        end
    endtask

    task automatic check_regs(input string tag);
        logic [2:0]       ef;
        logic [2:0][31:0] es;
        logic [2:0][3:0]  eb;
        ef = '0; es = '0; eb = '0;
        for (int p = 0; p < 3; p++) begin
            if (e_slot[p] >= 0) begin
                ef[p] = 1'b1;
                es[p][e_slot[p]] = 1'b1;
                eb[p][e_slot[p] / 8] = 1'b1;
            end
        end
        check_val({tag, "_found"}, rsFound, ef);
        check_val({tag, "_osel"}, outRsSelect, es);
        check_val({tag, "_obank"}, outBank, eb);
    endtask

    task automatic comb_phase();
        @(negedge clk);
        model_comb();
        check_val("doStall", doStall, c_stall);
        check_val("sel0", newRsSelect0, c_sel[0]);
        check_val("sel1", newRsSelect1, c_sel[1]);
        check_val("sel2", newRsSelect2, c_sel[2]);
        check_val("hitA", eqHitA, c_hit[0]);
        check_val("hitB", eqHitB, c_hit[1]);
        check_val("hitS", eqHitS, c_hit[2]);
        check_val("idxA", eqIdxA, c_idx[0]);
        check_val("idxB", eqIdxB, c_idx[1]);
        check_val("idxS", eqIdxS, c_idx[2]);
    endtask

    task automatic edge_phase();
        @(posedge clk);
        model_seq();
        #1;
        check_regs("reg");
    endtask

    task automatic cyc();
        comb_phase();
        edge_phase();
    endtask

    task automatic clr_in();
        stall = 0; flush = 0; newValid = '0; newPort = '0;
        newTagA = '0; newTagB = '0; newTagS = '0;
        newReadyA = '0; newReadyB = '0; newReadyS = '0; newUseS = '0;
        FUreg = '0; FUwen = '0;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1;
        rst = 0;
        check_regs("rst");
    endtask

    task automatic set_req(input int k, input int port, input int ta, input bit ra);
        newValid[k]  = 1'b1;
        newPort[k]   = 2'(port);
        newTagA[k]   = 9'(ta);
        newTagB[k]   = 9'd0;
        newTagS[k]   = 9'd0;
        newReadyA[k] = ra;
        newReadyB[k] = 1'b1;
        newReadyS[k] = 1'b1;
        newUseS[k]   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        rst = 1;

        // basic allocation and issue of three ready instructions
        do_reset();
        set_req(0, 0, 0, 1); set_req(1, 1, 0, 1); set_req(2, 2, 0, 1);
        comb_phase();
        check_val("t1_sel0", newRsSelect0, 32'h1);
        check_val("t1_sel1", newRsSelect1, 32'h2);
        check_val("t1_sel2", newRsSelect2, 32'h4);
        edge_phase();
        clr_in();
        cyc();
        check_val("t1_found", rsFound, 3'b111);
        check_val("t1_osel0", outRsSelect[0], 32'h1);
        check_val("t1_obank0", outBank[0], 4'b0001);

        // wakeup of slot 5 via FU3
        do_reset();
        for (int n = 0; n < 5; n++) begin
            set_req(n % 3, 1, 'h1FF, 0);
            if (n % 3 == 2 || n == 4) begin cyc(); clr_in(); end
        end
        set_req(0, 1, 'h23, 0);
        comb_phase();
        check_val("t2_sel0", newRsSelect0, 32'h20);
        edge_phase();
        clr_in();
        FUreg[3] = 9'h23; FUwen[3] = 1'b1;
        comb_phase();
        check_val("t2_hit5", eqHitA[5], 1'b1);
        check_val("t2_idx5", eqIdxA[5], 4'd3);
        edge_phase();
        check_val("t2_early", rsFound[1], 1'b0);
        clr_in();
        cyc();
        check_val("t2_found", rsFound[1], 1'b1);
        check_val("t2_osel", outRsSelect[1], 32'h20);
        check_val("t2_obank", outBank[1], 4'b0001);

        // nearly full buffer, stall, free one slot, retry, then completely full
        do_reset();
        for (int n = 0; n < 31; n++) begin
            set_req(n % 3, 0, (n == 7) ? 'h100 : 'h1FF, 0);
            if (n % 3 == 2 || n == 30) begin cyc(); clr_in(); end
        end
        set_req(0, 0, 'h1FF, 0); set_req(1, 0, 'h1FF, 0);
        comb_phase();
        check_val("t3_stall", doStall, 1'b1);
        check_val("t3_sel0z", newRsSelect0, 32'h0);
        check_val("t3_sel1z", newRsSelect1, 32'h0);
        edge_phase();
        clr_in();
        FUreg[0] = 9'h100; FUwen[0] = 1'b1;
        comb_phase();
        check_val("t3_hit7", eqHitA[7], 1'b1);
        edge_phase();
        clr_in();
        cyc();
        check_val("t3_iss7", outRsSelect[0], 32'h80);
        set_req(0, 0, 'h1FF, 0);
        comb_phase();
        check_val("t3_nostall", doStall, 1'b0);
        check_val("t3_retry", newRsSelect0, 32'h80);
        edge_phase();
        clr_in();
        set_req(0, 0, 'h1FF, 0);
        cyc();
        clr_in();
        comb_phase();
        check_val("t3_full_idle", doStall, 1'b0);
        edge_phase();
        set_req(0, 0, 'h1FF, 0);
        comb_phase();
        check_val("t3_full_req", doStall, 1'b1);
        edge_phase();
        clr_in();

        // bank rotation on port 0, plus lowest-FU priority on a double broadcast
        do_reset();
        for (int n = 0; n < 17; n++) begin
            if (n == 0 || n == 1 || n == 16) set_req(n % 3, 0, 'hAA, 0);
            else set_req(n % 3, 1, 'h1FF, 0);
            if (n % 3 == 2 || n == 16) begin cyc(); clr_in(); end
        end
        FUreg[1] = 9'hAA; FUwen[1] = 1'b1;
        FUreg[7] = 9'hAA; FUwen[7] = 1'b1;
        comb_phase();
        check_val("t4_idx0", eqIdxA[0], 4'd1);
        check_val("t4_hit16", eqHitA[16], 1'b1);
        check_val("t4_idx16", eqIdxA[16], 4'd1);
        edge_phase();
        clr_in();
        cyc();
        check_val("t4_osel_a", outRsSelect[0], 32'h1);
        check_val("t4_obank_a", outBank[0], 4'b0001);
        cyc();
        check_val("t4_osel_b", outRsSelect[0], 32'h0001_0000);
        check_val("t4_obank_b", outBank[0], 4'b0100);
        cyc();
        check_val("t4_osel_c", outRsSelect[0], 32'h2);
        check_val("t4_obank_c", outBank[0], 4'b0001);
        cyc();
        check_val("t4_idle", rsFound[0], 1'b0);

        // flush with ten valid slots and an issue pending
        do_reset();
        for (int n = 0; n < 9; n++) begin
            set_req(n % 3, 1, 'h1FF, 0);
            if (n % 3 == 2) begin cyc(); clr_in(); end
        end
        set_req(0, 2, 0, 1);
        cyc();
        clr_in();
        flush = 1'b1;
        comb_phase();
        check_val("t5_fl_stall", doStall, 1'b0);
        edge_phase();
        check_val("t5_found", rsFound, 3'b000);
        clr_in();
        set_req(0, 0, 0, 1); set_req(1, 1, 0, 1); set_req(2, 2, 0, 1);
        comb_phase();
        check_val("t5_sel0", newRsSelect0, 32'h1);
        check_val("t5_sel1", newRsSelect1, 32'h2);
        check_val("t5_sel2", newRsSelect2, 32'h4);
        edge_phase();
        clr_in();

        // random traffic, alternating quiet and busy broadcast phases
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int wen_pct;
            clr_in();
            wen_pct = (((c / 150) % 2) == 1) ? 20 : 3;
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < 3; k++) begin
                newValid[k]  = ($urandom_range(0, 3) != 0);
                newPort[k]   = 2'($urandom_range(0, 2));
                newTagA[k]   = 9'($urandom_range(0, 31));
                newTagB[k]   = 9'($urandom_range(0, 31));
                newTagS[k]   = 9'($urandom_range(0, 31));
                newReadyA[k] = ($urandom_range(0, 3) != 0);
                newReadyB[k] = ($urandom_range(0, 3) != 0);
                newReadyS[k] = ($urandom_range(0, 1) != 0);
                newUseS[k]   = ($urandom_range(0, 1) != 0);
            end
            for (int i = 0; i < 10; i++) begin
                FUwen[i] = ($urandom_range(0, 99) < wen_pct);
                FUreg[i] = 9'($urandom_range(0, 31));
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
